// File: rtl/fpu_pipe_pkg.sv
// Shared constants for the FPU pipeline controller: opcode bit positions,
// opcode class masks, flag bit positions and the supported latency range.
package fpu_pipe_pkg;

  localparam int OP_FADD    = 0;
  localparam int OP_FSUB    = 1;
  localparam int OP_FMUL    = 2;
  localparam int OP_FCVT_W  = 3;
  localparam int OP_FCVT_WU = 4;
  localparam int OP_FEQ     = 5;
  localparam int OP_FLT     = 6;
  localparam int OP_FLE     = 7;
  localparam int OP_FCLASS  = 8;
  localparam int OP_FMV_X   = 9;
  localparam int OP_FCVT_PW = 10;
  localparam int OP_FCVT_PU = 11;
  localparam int OP_FMADD   = 12;
  localparam int OP_FMSUB   = 13;
  localparam int OP_FMIN    = 14;
  localparam int OP_FMAX    = 15;
  localparam int OP_FNMSUB  = 16;
  localparam int OP_FNMADD  = 17;
  localparam int OP_FSGNJ   = 18;
  localparam int OP_FSGNJN  = 19;
  localparam int OP_FSGNJX  = 20;
  localparam int OP_FABS    = 21;
  localparam int OP_FNEG    = 22;
  localparam int OP_SIGN    = 23;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  localparam logic [23:0] MASK_FMA  = (24'd1 << OP_FADD)   | (24'd1 << OP_FSUB)   |
                                      (24'd1 << OP_FMUL)   | (24'd1 << OP_FMADD)  |
                                      (24'd1 << OP_FMSUB)  | (24'd1 << OP_FNMSUB) |
                                      (24'd1 << OP_FNMADD);
  localparam logic [23:0] MASK_INT  = (24'd1 << OP_FCVT_W) | (24'd1 << OP_FCVT_WU) |
                                      (24'd1 << OP_FEQ)    | (24'd1 << OP_FLT)     |
                                      (24'd1 << OP_FLE)    | (24'd1 << OP_FCLASS);
  localparam logic [23:0] MASK_MVX  = (24'd1 << OP_FMV_X);
  localparam logic [23:0] MASK_CVTF = (24'd1 << OP_FCVT_PW) | (24'd1 << OP_FCVT_PU);

  typedef enum logic [2:0] {
    CLS_BAD,
    CLS_FMA,
    CLS_INT,
    CLS_MVX,
    CLS_CVTF,
    CLS_FPO
  } res_cls_e;

endpackage

// File: rtl/fpu_pipe_ctrl_if.sv
// Request, datapath and result signals of the FPU pipeline controller.
// The slave modport is the controller; master is the surrounding core.
interface fpu_pipe_ctrl_if #(
  parameter int W   = 16,
  parameter int OPW = 24
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [2:0]     in_frm;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [W-1:0]   in_c;
  logic [31:0]    in_int;

  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic [W-1:0]   dp_c;
  logic [OPW-1:0] dp_op;
  logic [2:0]     dp_frm;
  logic [31:0]    dp_int;
  logic [W-1:0]   dp_fp_res;
  logic [31:0]    dp_int_res;
  logic [4:0]     dp_flags;
  logic           dp_exc;

  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_fp;
  logic [31:0]    out_rd;
  logic [4:0]     out_flags;

  logic [4:0]     fflags;
  logic           fflags_clr;
  logic           irq_en;
  logic           irq;

  modport master (
    output in_valid, in_op, in_frm, in_a, in_b, in_c, in_int,
    output dp_fp_res, dp_int_res, dp_flags, dp_exc,
    output out_ready, fflags_clr, irq_en,
    input  in_ready, dp_a, dp_b, dp_c, dp_op, dp_frm, dp_int,
    input  out_valid, out_fp, out_rd, out_flags, fflags, irq
  );

  modport slave (
    input  in_valid, in_op, in_frm, in_a, in_b, in_c, in_int,
    input  dp_fp_res, dp_int_res, dp_flags, dp_exc,
    input  out_ready, fflags_clr, irq_en,
    output in_ready, dp_a, dp_b, dp_c, dp_op, dp_frm, dp_int,
    output out_valid, out_fp, out_rd, out_flags, fflags, irq
  );
endinterface

// File: rtl/fpu_pipe_stage.sv
// One result pipeline stage: valid bit with reset plus an enable-gated payload.
module fpu_pipe_stage #(
  parameter int PW = 54
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_vld,
  input  logic [PW-1:0] i_data,
  output logic          o_vld,
  output logic [PW-1:0] o_data
);
  logic          r_vld;
  logic [PW-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (i_en) begin
      r_vld <= i_vld;
    end
  end

  // Payload only moves with a valid beat; consumers gate it with o_vld.
  always_ff @(posedge clk) begin
    if (i_en && i_vld) begin
      r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
endmodule

// File: rtl/fpu_pipe_ctrl.sv
// Scalar FPU pipeline controller: registers operands for the datapath,
// formats its results per opcode class and tracks sticky flags and the irq.
module fpu_pipe_ctrl
  import fpu_pipe_pkg::*;
#(
  parameter int W   = 16,
  parameter int LAT = 2,
  parameter int OPW = 24
) (
  input logic           clk,
  input logic           rst,
  fpu_pipe_ctrl_if.slave bus
);
  localparam int NSTG = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
  localparam int LAST = NSTG - 1;
  localparam int PW   = W + 32 + 5 + 1;

  localparam logic [OPW-1:0] M_FMA  = OPW'(MASK_FMA);
  localparam logic [OPW-1:0] M_INT  = OPW'(MASK_INT);
  localparam logic [OPW-1:0] M_MVX  = OPW'(MASK_MVX);
  localparam logic [OPW-1:0] M_CVTF = OPW'(MASK_CVTF);

  logic           w_adv;
  logic           w_out_vld;
  logic           w_out_hs;
  logic [PW-1:0]  w_out_pay;
  logic [W-1:0]   w_out_fp;
  logic [31:0]    w_out_rd;
  logic [4:0]     w_out_flags;
  logic           w_out_exc;

  logic           r_vld_p0;
  logic [OPW-1:0] r_op_p0;
  logic [2:0]     r_frm_p0;
  logic [W-1:0]   r_a_p0;
  logic [W-1:0]   r_b_p0;
  logic [W-1:0]   r_c_p0;
  logic [31:0]    r_int_p0;

  res_cls_e       w_cls;
  logic [W-1:0]   w_res_fp;
  logic [31:0]    w_res_rd;
  logic [4:0]     w_res_flags;
  logic           w_res_exc;

  logic           w_vld [NSTG];
  logic [PW-1:0]  w_pay [NSTG];

  logic [4:0]     r_fflags;
  logic           r_irq;

  function automatic res_cls_e classify(input logic [OPW-1:0] op);
    if (!$onehot(op))     return CLS_BAD;
    if (|(op & M_FMA))    return CLS_FMA;
    if (|(op & M_INT))    return CLS_INT;
    if (|(op & M_MVX))    return CLS_MVX;
    if (|(op & M_CVTF))   return CLS_CVTF;
    return CLS_FPO;
  endfunction

  assign w_adv        = ~w_out_vld | bus.out_ready;
  assign bus.in_ready = w_adv;

  // ---- stage 0: operand registers feeding the datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_op_p0  <= '0;
      r_frm_p0 <= '0;
      r_a_p0   <= '0;
      r_b_p0   <= '0;
      r_c_p0   <= '0;
      r_int_p0 <= '0;
    end else if (w_adv) begin
      r_vld_p0 <= bus.in_valid;
      if (bus.in_valid) begin
        r_op_p0  <= bus.in_op;
        r_frm_p0 <= bus.in_frm;
        r_a_p0   <= bus.in_a;
        r_b_p0   <= bus.in_b;
        r_c_p0   <= bus.in_c;
        r_int_p0 <= bus.in_int;
      end
    end
  end

  assign bus.dp_a   = r_a_p0;
  assign bus.dp_b   = r_b_p0;
  assign bus.dp_c   = r_c_p0;
  assign bus.dp_op  = r_op_p0;
  assign bus.dp_frm = r_frm_p0;
  assign bus.dp_int = r_int_p0;

  // Malformed opcodes win over dp_exc: the datapath result is meaningless then.
  always_comb begin
    w_cls       = classify(r_op_p0);
    w_res_fp    = '0;
    w_res_rd    = '0;
    w_res_flags = '0;
    w_res_exc   = 1'b0;
    if (w_cls == CLS_BAD) begin
      w_res_flags[FL_NV] = 1'b1;
    end else if (bus.dp_exc) begin
      w_res_exc          = 1'b1;
      w_res_fp           = bus.dp_fp_res;
      w_res_rd           = 32'(bus.dp_fp_res);
      w_res_flags[FL_NV] = bus.dp_flags[FL_NV];
      w_res_flags[FL_DZ] = bus.dp_flags[FL_DZ];
    end else begin
      unique case (w_cls)
        CLS_FMA: begin
          w_res_fp         = bus.dp_fp_res;
          w_res_flags[2:0] = bus.dp_flags[2:0];
        end
        CLS_INT: begin
          w_res_rd           = bus.dp_int_res;
          w_res_flags[FL_NV] = bus.dp_flags[FL_NV];
          w_res_flags[FL_NX] = bus.dp_flags[FL_NX];
        end
        CLS_MVX: begin
          w_res_fp = bus.dp_fp_res;
          w_res_rd = bus.dp_int_res;
        end
        CLS_CVTF: begin
          w_res_fp           = bus.dp_fp_res;
          w_res_flags[FL_NV] = bus.dp_flags[FL_NV];
          w_res_flags[FL_NX] = bus.dp_flags[FL_NX];
        end
        default: begin
          w_res_fp = bus.dp_fp_res;
        end
      endcase
    end
  end

  assign w_vld[0] = r_vld_p0;
  assign w_pay[0] = {w_res_exc, w_res_flags, w_res_rd, w_res_fp};

  // ---- stages 1..LAT-1: formatted result registers ----
  for (genvar k = 1; k < NSTG; k++) begin : g_stage
    fpu_pipe_stage #(.PW(PW)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_adv),
      .i_vld  (w_vld[k-1]),
      .i_data (w_pay[k-1]),
      .o_vld  (w_vld[k]),
      .o_data (w_pay[k])
    );
  end

  assign w_out_vld   = w_vld[LAST];
  assign w_out_pay   = w_out_vld ? w_pay[LAST] : '0;
  assign w_out_fp    = w_out_pay[W-1:0];
  assign w_out_rd    = w_out_pay[W+31:W];
  assign w_out_flags = w_out_pay[W+36:W+32];
  assign w_out_exc   = w_out_pay[W+37];
  assign w_out_hs    = w_out_vld & bus.out_ready;

  // ---- output: sticky flags and exception interrupt ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fflags <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_fflags <= (bus.fflags_clr ? 5'b0 : r_fflags) | (w_out_hs ? w_out_flags : 5'b0);
      r_irq    <= (r_irq & ~bus.fflags_clr) | (w_out_hs & w_out_exc & bus.irq_en);
    end
  end

  assign bus.out_valid = w_out_vld;
  assign bus.out_fp    = w_out_fp;
  assign bus.out_rd    = w_out_rd;
  assign bus.out_flags = w_out_flags;
  assign bus.fflags    = r_fflags;
  assign bus.irq       = r_irq;
endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Directed bench for fpu_pipe_ctrl (W=16, LAT=2) with a scripted datapath.
module tb_fpu_pipe_ctrl;
  localparam int W   = 16;
  localparam int LAT = 2;
  localparam int OPW = 24;

  localparam logic [23:0] OP_FADD   = 24'h000001;
  localparam logic [23:0] OP_FMUL   = 24'h000004;
  localparam logic [23:0] OP_FCVTW  = 24'h000008;
  localparam logic [23:0] OP_FEQ    = 24'h000020;
  localparam logic [23:0] OP_FMVX   = 24'h000200;
  localparam logic [23:0] OP_FCVTPW = 24'h000400;
  localparam logic [23:0] OP_FSGNJ  = 24'h040000;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] tb_fp_res;
  logic [31:0] tb_int_res;
  logic [4:0]  tb_flags;
  logic        tb_exc;
  logic        tb_auto;

  fpu_pipe_ctrl_if #(.W(W), .OPW(OPW)) bus ();

  fpu_pipe_ctrl #(.W(W), .LAT(LAT), .OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scripted datapath; auto mode returns dp_a + 0x0100 so streams are traceable.
  always_comb begin
    bus.dp_fp_res  = tb_auto ? (bus.dp_a + 16'h0100) : tb_fp_res;
    bus.dp_int_res = tb_int_res;
    bus.dp_flags   = tb_flags;
    bus.dp_exc     = tb_exc;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [23:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_fp !== 16'h0) begin errors++; $display("FAIL reset_out_fp: got %h want 0", bus.out_fp); end
    checks++; if (bus.out_rd !== 32'h0) begin errors++; $display("FAIL reset_out_rd: got %h want 0", bus.out_rd); end
    checks++; if (bus.out_flags !== 5'b0) begin errors++; $display("FAIL reset_out_flags: got %b want 0", bus.out_flags); end
    checks++; if (bus.fflags !== 5'b0) begin errors++; $display("FAIL reset_fflags: got %b want 0", bus.fflags); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    checks++; if (bus.dp_a !== 16'h0 || bus.dp_op !== 24'h0) begin errors++; $display("FAIL reset_dp: got a=%h op=%h want 0", bus.dp_a, bus.dp_op); end
  endtask

  task automatic test_fadd();
    int lat;
    tb_auto = 1'b0; tb_fp_res = 16'h4040; tb_int_res = 32'h0; tb_flags = 5'b0; tb_exc = 1'b0;
    issue(OP_FADD, 16'h3F80, 16'h4000, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL fadd_latency: got %0d want 2", lat); end
    checks++; if (bus.out_fp !== 16'h4040) begin errors++; $display("FAIL fadd_out_fp: got %h want 4040", bus.out_fp); end
    checks++; if (bus.out_flags !== 5'b0 || bus.out_rd !== 32'h0) begin errors++; $display("FAIL fadd_flags_rd: got %b/%h want 0/0", bus.out_flags, bus.out_rd); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fadd_retire: got out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_fcvt();
    int lat;
    tb_fp_res = 16'h5555; tb_int_res = 32'h00000003; tb_flags = 5'b00001;
    issue(OP_FCVTW, 16'h4040, 16'h0, lat);
    checks++; if (bus.out_rd !== 32'h3) begin errors++; $display("FAIL fcvt_out_rd: got %h want 3", bus.out_rd); end
    checks++; if (bus.out_fp !== 16'h0) begin errors++; $display("FAIL fcvt_out_fp: got %h want 0", bus.out_fp); end
    checks++; if (bus.out_flags !== 5'b00001) begin errors++; $display("FAIL fcvt_out_flags: got %b want 00001", bus.out_flags); end
    tick();
    checks++; if (bus.fflags !== 5'b00001) begin errors++; $display("FAIL fcvt_fflags: got %b want 00001", bus.fflags); end
  endtask

  task automatic test_exc_irq();
    int lat;
    bus.irq_en = 1'b1;
    tb_exc = 1'b1; tb_fp_res = 16'h7FC0; tb_int_res = 32'h1234; tb_flags = 5'b10000;
    issue(OP_FADD, 16'h7F80, 16'hFF80, lat);
    checks++; if (bus.out_fp !== 16'h7FC0) begin errors++; $display("FAIL exc_out_fp: got %h want 7fc0", bus.out_fp); end
    checks++; if (bus.out_rd !== 32'h00007FC0) begin errors++; $display("FAIL exc_out_rd: got %h want 00007fc0", bus.out_rd); end
    checks++; if (bus.out_flags !== 5'b10000) begin errors++; $display("FAIL exc_out_flags: got %b want 10000", bus.out_flags); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL exc_irq_early: got %b want 0", bus.irq); end
    tick();
    tb_exc = 1'b0;
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL exc_irq_set: got %b want 1", bus.irq); end
    checks++; if (bus.fflags !== 5'b10001) begin errors++; $display("FAIL exc_fflags: got %b want 10001", bus.fflags); end
    bus.irq_en = 1'b0;
    tick();
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL exc_irq_hold: got %b want 1", bus.irq); end
    bus.fflags_clr = 1'b1;
    tick();
    bus.fflags_clr = 1'b0;
    checks++; if (bus.irq !== 1'b0 || bus.fflags !== 5'b0) begin errors++; $display("FAIL exc_clear: got irq=%b fflags=%b want 0/00000", bus.irq, bus.fflags); end
  endtask

  task automatic test_classes();
    logic [23:0] ops    [6] = '{OP_FMUL, OP_FMVX, OP_FCVTPW, OP_FSGNJ, OP_FEQ, 24'h000000};
    logic [15:0] fps    [6] = '{16'h4100, 16'h3C00, 16'h4040, 16'hBF80, 16'h1111, 16'h2222};
    logic [31:0] ints   [6] = '{32'hDEAD, 32'hBEEF, 32'h7, 32'h9, 32'h1, 32'h5};
    logic [15:0] exp_fp [6] = '{16'h4100, 16'h3C00, 16'h4040, 16'hBF80, 16'h0000, 16'h0000};
    logic [31:0] exp_rd [6] = '{32'h0, 32'hBEEF, 32'h0, 32'h0, 32'h1, 32'h0};
    logic [4:0]  exp_fl [6] = '{5'b00111, 5'b00000, 5'b10001, 5'b00000, 5'b10001, 5'b10000};
    int lat;
    for (int i = 0; i < 6; i++) begin
      tb_fp_res = fps[i]; tb_int_res = ints[i]; tb_flags = 5'b11111; tb_exc = 1'b0;
      issue(ops[i], 16'h1234, 16'h5678, lat);
      checks++;
      if (bus.out_fp !== exp_fp[i] || bus.out_rd !== exp_rd[i] || bus.out_flags !== exp_fl[i]) begin
        errors++;
        $display("FAIL class_%0d: got fp=%h rd=%h fl=%b want fp=%h rd=%h fl=%b",
                 i, bus.out_fp, bus.out_rd, bus.out_flags, exp_fp[i], exp_rd[i], exp_fl[i]);
      end
      tick();
    end
  endtask

  task automatic test_bad_op();
    int lat;
    bus.fflags_clr = 1'b1;
    tick();
    bus.fflags_clr = 1'b0;
    tb_fp_res = 16'h4000; tb_int_res = 32'h0; tb_flags = 5'b00100; tb_exc = 1'b0;
    issue(OP_FMUL, 16'h3F80, 16'h4000, lat);
    tick();
    checks++; if (bus.fflags !== 5'b00100) begin errors++; $display("FAIL badop_pre_fflags: got %b want 00100", bus.fflags); end
    tb_fp_res = 16'h1234; tb_int_res = 32'h55; tb_flags = 5'b11111;
    issue(24'h000003, 16'h1111, 16'h2222, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL badop_latency: got %0d want 2", lat); end
    checks++; if (bus.out_flags !== 5'b10000) begin errors++; $display("FAIL badop_flags: got %b want 10000", bus.out_flags); end
    checks++; if (bus.out_fp !== 16'h0 || bus.out_rd !== 32'h0) begin errors++; $display("FAIL badop_result: got %h/%h want 0/0", bus.out_fp, bus.out_rd); end
    bus.fflags_clr = 1'b1;
    tick();
    bus.fflags_clr = 1'b0;
    checks++; if (bus.fflags !== 5'b10000) begin errors++; $display("FAIL badop_fflags_clr: got %b want 10000", bus.fflags); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL badop_retire: got out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    int issued = 0;
    int retired = 0;
    int stalls = 0;
    tb_auto = 1'b1; tb_flags = 5'b0; tb_exc = 1'b0; tb_int_res = 32'h0;
    for (int c = 0; c < 25; c++) begin
      bus.out_ready = !(c >= 2 && c <= 4);
      bus.in_valid  = (issued < 4);
      bus.in_op     = OP_FADD;
      bus.in_a      = 16'(issued + 1);
      bus.in_b      = 16'h0;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready c%0d: got %b want 0", c, bus.in_ready); end
        checks++;
        if (exp_q.size() == 0 || bus.out_fp !== exp_q[0]) begin
          errors++; $display("FAIL b2b_stall_hold c%0d: got %h want head of queue", c, bus.out_fp);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        retired++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra c%0d: got %h want no result", c, bus.out_fp);
        end else begin
          if (bus.out_fp !== exp_q[0]) begin
            errors++; $display("FAIL b2b_order c%0d: got %h want %h", c, bus.out_fp, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(16'(issued + 1) + 16'h0100);
        issued++;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (stalls !== 3) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want 3", stalls); end
    checks++;
    if (issued !== 4 || retired !== 4 || exp_q.size() !== 0) begin
      errors++; $display("FAIL b2b_count: got issued=%0d retired=%0d left=%0d want 4/4/0", issued, retired, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int ghosts = 0;
    tb_auto = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = OP_FADD;
    bus.in_a      = 16'h0010;
    tick();
    bus.in_a      = 16'h0020;
    tick();
    bus.in_valid  = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.dp_a !== 16'h0020) begin errors++; $display("FAIL midrst_inflight: got out_valid=%b dp_a=%h want 1/0020", bus.out_valid, bus.dp_a); end
    checks++; if (bus.fflags !== 5'b10000) begin errors++; $display("FAIL midrst_pre_fflags: got %b want 10000", bus.fflags); end
    rst = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.fflags !== 5'b0) begin errors++; $display("FAIL midrst_fflags: got %b want 0", bus.fflags); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.dp_a !== 16'h0) begin errors++; $display("FAIL midrst_dp_a: got %h want 0", bus.dp_a); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid) ghosts++;
      tick();
    end
    checks++; if (ghosts !== 0) begin errors++; $display("FAIL midrst_ghosts: got %0d results want 0", ghosts); end
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_frm     = 3'b000;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_c       = '0;
    bus.in_int     = '0;
    bus.out_ready  = 1'b1;
    bus.fflags_clr = 1'b0;
    bus.irq_en     = 1'b0;
    tb_auto        = 1'b0;
    tb_fp_res      = '0;
    tb_int_res     = '0;
    tb_flags       = '0;
    tb_exc         = 1'b0;

    test_reset();
    test_fadd();
    test_fcvt();
    test_exc_irq();
    test_classes();
    test_bad_op();
    test_back_to_back();
    test_reset_midflight();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_pipe_ctrl.md
FPU_PIPE_CTRL -- requirements
Module: fpu_pipe_ctrl

Interface
REQ-001 Parameter W, default 16: FP operand/result width (16 = bfloat16, 32 = single).
REQ-002 Parameter LAT, default 2, legal 1..4: cycles from input handshake to out_valid.
REQ-003 Parameter OPW, default 24: one-hot scalar opcode width (bit 0 FADD … bit 23 SIGN).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  request handshake.
REQ-007 in_op  in  OPW  one-hot opcode; in_frm  in  3  rounding mode.
REQ-008 in_a, in_b, in_c  in  W  FP operands; in_int  in  32  integer operand.
REQ-009 dp_a, dp_b, dp_c, dp_op, dp_frm, dp_int  out  W/W/W/OPW/3/32  registered operands driven to datapath units.
REQ-010 dp_fp_res  in  W; dp_int_res  in  32; dp_flags  in  5 {NV,DZ,OF,UF,NX}; dp_exc  in  1: combinational datapath returns.
REQ-011 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-012 out_fp  out  W; out_rd  out  32; out_flags  out  5: result payload.
REQ-013 fflags  out  5  sticky accrued flags; fflags_clr  in  1  clear request.
REQ-014 irq_en  in  1; irq  out  1  exception interrupt.

Function
REQ-015 adv = ~out_valid | out_ready; in_ready SHALL equal adv; all stages shift only when adv=1.
REQ-016 Input handshake (in_valid & in_ready) SHALL load stage 0 with operands/opcode/frm and set valid0; otherwise, when adv=1, valid0 SHALL clear.
REQ-017 Datapath returns SHALL be sampled into stage 1 from stage-0 registers; with LAT=1 stage 0 feeds the output directly through the result mux.
REQ-018 With out_ready held high, a request accepted at cycle t SHALL present out_valid at t+LAT; throughput one result per cycle.
REQ-019 When out_valid=1 and out_ready=0, payload SHALL remain stable and no new request SHALL be accepted.
REQ-020 Result mux priority: dp_exc -> out_fp=dp_fp_res, out_rd=zero-extended dp_fp_res, out_flags={dp_flags[4:3],000}; FMA-class ops (bits 0,1,12,13,16,17) and FMUL -> out_fp=dp_fp_res, out_rd=0, flags {00,dp_flags[2:0]}; FCVT.W.P, compare, FCLASS -> out_fp=0, out_rd=dp_int_res; FMV.X -> both fields; FCVT.P.W -> out_fp=dp_fp_res with NV,NX; sign-inject, min/max -> out_fp only, flags 0.
REQ-021 Opcode with zero or more than one bit set SHALL produce out_fp=0, out_rd=0, out_flags=10000 and SHALL still complete the handshake.
REQ-022 fflags_next = (fflags_clr ? 0 : fflags) | (out_valid & out_ready ? out_flags : 0); a clear and a retiring result in the same cycle leave only the new flags.
REQ-023 irq SHALL set on an output handshake of a dp_exc-tagged result while irq_en=1, and hold until fflags_clr.
REQ-024 Deasserting irq_en SHALL NOT clear an asserted irq.

Reset
REQ-025 rst SHALL clear every stage valid, out_valid, out_fp, out_rd, out_flags, fflags, irq, dp_* to 0; in_ready=1 in the first cycle after reset.
REQ-026 rst mid-operation SHALL discard all in-flight results without a handshake.

Structure
REQ-027 Package fpu_pipe_pkg SHALL hold opcode bit indices, flag bit positions and the legal LAT range.
REQ-028 One sub-module fpu_pipe_stage (valid + payload register with enable) SHALL be instantiated LAT-1 times via generate.

Verification
REQ-029 W=16, LAT=2, FADD a=0x3F80, b=0x4000, dp_fp_res=0x4040 -> out_valid at t+2, out_fp=0x4040, out_flags=0.
REQ-030 Back-to-back 4 requests with out_ready=0 for 3 cycles -> in_ready low while stalled, all 4 results in order, none lost or duplicated.
REQ-031 FCVT.W.P with dp_int_res=0x00000003, dp_flags=00001 -> out_rd=3, out_fp=0, fflags=00001.
REQ-032 dp_exc=1, dp_fp_res=0x7FC0, dp_flags=10000, irq_en=1 -> out_fp=0x7FC0, out_rd=0x00007FC0, irq=1 until fflags_clr.
REQ-033 in_op=0x000003 -> out_flags=10000, result zero; fflags_clr coincident with it -> fflags=10000.
REQ-034 rst asserted with 2 results in flight -> next cycle out_valid=0, fflags=0, in_ready=1.
